// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS pipeline stages.
// Holds the IF/ID register layout, the bubble value and the text-segment range check.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
    localparam logic [31:0] TEXT_START_DEFAULT = 32'h0040_0000;
    localparam int unsigned TEXT_BYTES_DEFAULT = 1024;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, instr: NOP_INSTR, pc_plus4: 32'h0};

    // Word-aligned and inside [base, base+bytes); the offset compare avoids overflow at the top.
    function automatic logic is_text_addr(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] bytes);
        logic [31:0] off;
        off = addr - base;
        return (addr[1:0] == 2'b00) && (addr >= base) && (off < bytes);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage and its surroundings (hazard unit, branch unit, imem, ID stage).
// master = fetch stage side, slave = environment side.
interface fetch_stage_if #(
    parameter int CNT_W = 32
);

    logic             stall_if;
    logic             flush_if;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic [31:0]      pc;
    logic             if_id_valid;
    logic [31:0]      if_id_instr;
    logic [31:0]      if_id_pc_plus4;
    logic             fetch_fault;
    logic [CNT_W-1:0] fetched_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        input  stall_if, flush_if, redirect_valid, redirect_pc, imem_rdata,
        output imem_addr, pc, if_id_valid, if_id_instr, if_id_pc_plus4,
               fetch_fault, fetched_cnt, stall_cnt
    );

    modport slave (
        output stall_if, flush_if, redirect_valid, redirect_pc, imem_rdata,
        input  imem_addr, pc, if_id_valid, if_id_instr, if_id_pc_plus4,
               fetch_fault, fetched_cnt, stall_cnt
    );

endinterface

// File: rtl/fetch_stage_sat_counter.sv
// Saturating up-counter: clr wins, then en adds one unless already all-ones.
// Latency: count visible the edge after en. No backpressure.
// clr is synchronous.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, imem address, IF/ID register, sticky fetch fault, debug counters.
// Latency: word at pc lands in IF/ID on the next posedge.
// Backpressure: stall_if holds pc and IF/ID; redirect overrides stall/flush/fault.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] TEXT_START = TEXT_START_DEFAULT,
    parameter int unsigned TEXT_BYTES = TEXT_BYTES_DEFAULT,
    parameter int          CNT_W      = 32
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    if_id_t      if_id_q;
    if_id_t      if_id_d;
    logic        fault_q;
    logic        fault_d;

    logic [31:0] pc_plus4;
    logic        pc_legal;
    logic        redirect_legal;
    logic        fetch_en;
    logic        stall_en;
    logic [CNT_W-1:0] fetched_cnt;
    logic [CNT_W-1:0] stall_cnt;

    assign pc_plus4       = pc_q + 32'd4;
    assign pc_legal       = is_text_addr(pc_q, TEXT_START, 32'(TEXT_BYTES));
    assign redirect_legal = is_text_addr(bus.redirect_pc, TEXT_START, 32'(TEXT_BYTES));

    always_comb begin
        pc_d     = pc_q;
        if_id_d  = if_id_q;
        fault_d  = fault_q;
        fetch_en = 1'b0;
        stall_en = 1'b0;
        if (bus.redirect_valid) begin
            pc_d    = bus.redirect_pc;
            if_id_d = IF_ID_BUBBLE;
            fault_d = !redirect_legal;
        end else begin
            stall_en = bus.stall_if;
            if (fault_q) begin
                if_id_d = IF_ID_BUBBLE;
            end else if (bus.stall_if) begin
                if (bus.flush_if) begin
                    if_id_d = IF_ID_BUBBLE;
                end
            end else if (!pc_legal) begin
                // Freeze on the offending address so the debugger sees where fetch left text.
                fault_d = 1'b1;
                if_id_d = IF_ID_BUBBLE;
            end else begin
                pc_d = pc_plus4;
                if (bus.flush_if) begin
                    if_id_d = IF_ID_BUBBLE;
                end else begin
                    if_id_d  = '{valid: 1'b1, instr: bus.imem_rdata, pc_plus4: pc_plus4};
                    fetch_en = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= TEXT_START;
            if_id_q <= IF_ID_BUBBLE;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
            fault_q <= fault_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_fetched_cnt (
        .clk (clk),
        .clr (rst),
        .en  (fetch_en),
        .cnt (fetched_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .en  (stall_en),
        .cnt (stall_cnt)
    );

    assign bus.imem_addr      = pc_q;
    assign bus.pc             = pc_q;
    assign bus.if_id_valid    = if_id_q.valid;
    assign bus.if_id_instr    = if_id_q.instr;
    assign bus.if_id_pc_plus4 = if_id_q.pc_plus4;
    assign bus.fetch_fault    = fault_q;
    assign bus.fetched_cnt    = fetched_cnt;
    assign bus.stall_cnt      = stall_cnt;

endmodule
